// File: rtl/access_initiator.sv
// Host-side initiator: on start, streams a write command plus NREGWR source bytes,
// then a read command, captures the returned byte into result, sends the dummy byte and pulses done.
// dataw/valid are registered; src_addr is combinational and runs one fetch ahead of the byte stream.

module access_initiator #(
   parameter int SIZE_WORD = 8,
   parameter int NREGWR    = 121,
   parameter int NREGR     = 1,
   parameter int RD_ADDR   = 121,
   parameter int GAP       = 0,
   parameter int TIMEOUT   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      rd_only,
   output logic                      busy,
   output logic [$clog2(NREGWR)-1:0] src_addr,
   input  logic [SIZE_WORD-1:0]      src_data,
   output logic [SIZE_WORD-1:0]      dataw,
   output logic                      valid,
   input  logic                      ready,
   input  logic [SIZE_WORD-1:0]      datar,
   output logic [SIZE_WORD-1:0]      result,
   output logic                      done,
   output logic                      err
);

   localparam int AW    = $clog2(NREGWR);
   localparam int DRAIN = (GAP > 1) ? GAP : 1;
   localparam int GAPM1 = (GAP > 0) ? GAP - 1 : 0;
   localparam int LW    = $clog2(DRAIN + 1);
   localparam int TW    = $clog2(TIMEOUT + 1);

   localparam logic [AW-1:0]        LAST   = AW'(NREGWR - 1);
   localparam logic [TW-1:0]        TLAST  = TW'(TIMEOUT - 1);
   localparam logic [SIZE_WORD-1:0] WR_CMD = {1'b1, {(SIZE_WORD-1){1'b0}}};
   localparam logic [SIZE_WORD-1:0] RD_CMD = SIZE_WORD'(RD_ADDR);

   // Address space (write + read registers) must fit below the command MSB.
   if ($clog2(NREGWR + NREGR) > SIZE_WORD - 1) begin : g_addr_chk
      $error("access_initiator: register address space does not fit in SIZE_WORD-1 bits");
   end

   typedef enum logic [2:0] {IDLE, WCMD, WDATA, WDRAIN, RCMD, RWAIT, RDUMMY, DONE} state_t;

   state_t           state, next_state;
   logic             fire;
   logic [SIZE_WORD-1:0] fire_dat;
   logic [AW-1:0]    cnt;        // index of the next data byte to emit
   logic [LW-1:0]    low_cnt;    // consecutive valid-low cycles before the current one (saturating)
   logic [TW-1:0]    tcnt;       // cycles spent waiting for ready
   logic             accept, can_gap, can_drain, timeout, rd_end;

   assign accept    = (state == IDLE) && start && !busy;
   // A pulse may be launched at the end of this cycle once the low run including it reaches the spacing.
   assign can_gap   = (GAP == 0) ? 1'b1 : (!valid && (low_cnt >= LW'(GAPM1)));
   assign can_drain = !valid && (low_cnt >= LW'(DRAIN - 1));
   assign timeout   = (tcnt == TLAST);
   assign rd_end    = ready || timeout;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic: each phase waits for its spacing before launching its byte
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) begin
                     if (rd_only) next_state = can_gap ? RWAIT : RCMD;
                     else         next_state = can_gap ? WDATA : WCMD;
                  end
         WCMD:    if (can_gap) next_state = WDATA;
         WDATA:   if (can_gap && cnt == LAST) next_state = WDRAIN;
         WDRAIN:  if (can_drain) next_state = RWAIT;
         RCMD:    if (can_gap) next_state = RWAIT;
         RWAIT:   if (rd_end) next_state = can_gap ? DONE : RDUMMY;
         RDUMMY:  if (can_gap) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode: which byte is launched this cycle, and the prefetch address
   always_comb begin
      fire     = 1'b0;
      fire_dat = '0;
      src_addr = cnt;
      case (state)
         IDLE:    if (accept && can_gap) begin
                     fire     = 1'b1;
                     fire_dat = rd_only ? RD_CMD : WR_CMD;
                  end
         WCMD:    if (can_gap) begin
                     fire     = 1'b1;
                     fire_dat = WR_CMD;
                  end
         WDATA:   if (can_gap) begin
                     fire     = 1'b1;
                     fire_dat = src_data;
                     if (cnt != LAST) src_addr = cnt + AW'(1);
                  end
         WDRAIN:  if (can_drain) begin
                     fire     = 1'b1;
                     fire_dat = RD_CMD;
                  end
         RCMD:    if (can_gap) begin
                     fire     = 1'b1;
                     fire_dat = RD_CMD;
                  end
         RWAIT:   if (rd_end && can_gap) fire = 1'b1;
         RDUMMY:  if (can_gap) fire = 1'b1;
         default: ;
      endcase
   end

   // Registered outputs, byte counter, spacing and timeout counters
   always_ff @(posedge clk) begin
      if (rst) begin
         valid   <= 1'b0;
         dataw   <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
         result  <= '0;
         cnt     <= '0;
         low_cnt <= '0;
         tcnt    <= '0;
      end else begin
         valid <= fire;
         dataw <= fire_dat;
         done  <= (state == DONE);

         if (accept)    busy <= 1'b1;
         else if (done) busy <= 1'b0;

         if (valid)                     low_cnt <= '0;
         else if (low_cnt != LW'(DRAIN)) low_cnt <= low_cnt + LW'(1);

         if (state == IDLE)                                  cnt <= '0;
         else if (state == WDATA && can_gap && cnt != LAST)  cnt <= cnt + AW'(1);

         if (state != RWAIT) tcnt <= '0;
         else if (!timeout)  tcnt <= tcnt + TW'(1);

         if (state == RWAIT && ready) result <= datar;

         if (accept)                                      err <= 1'b0;
         else if (state == RWAIT && !ready && timeout)    err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_access_initiator.sv
// Bench for access_initiator: two instances (GAP=0 and GAP=2) run the same randomized sequences;
// a controller/memory model answers them and a stream-level reference model checks the results.
module tb_access_initiator;

   localparam int NW = 4;
   localparam int RA = 4;
   localparam int TO = 16;
   localparam int NBUF = 1024;

   logic       clk = 1'b0;
   logic       rst, start, rd_only;
   logic [7:0] datar;
   logic       busy[2], valid[2], done[2], err[2], ready[2];
   logic [1:0] src_addr[2];
   logic [7:0] src_data[2], dataw[2], result[2];

   always #5 clk = ~clk;

   access_initiator #(.SIZE_WORD(8), .NREGWR(NW), .NREGR(1), .RD_ADDR(RA), .GAP(0), .TIMEOUT(TO)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .rd_only(rd_only), .busy(busy[0]),
      .src_addr(src_addr[0]), .src_data(src_data[0]), .dataw(dataw[0]), .valid(valid[0]),
      .ready(ready[0]), .datar(datar), .result(result[0]), .done(done[0]), .err(err[0]));

   access_initiator #(.SIZE_WORD(8), .NREGWR(NW), .NREGR(1), .RD_ADDR(RA), .GAP(2), .TIMEOUT(TO)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .rd_only(rd_only), .busy(busy[1]),
      .src_addr(src_addr[1]), .src_data(src_data[1]), .dataw(dataw[1]), .valid(valid[1]),
      .ready(ready[1]), .datar(datar), .result(result[1]), .done(done[1]), .err(err[1]));

   // environment state
   logic [7:0] mem[NW];
   int         cyc = 0;
   bit         resp_en = 1'b0;
   bit         stray = 1'b0;
   bit         seq_rdo = 1'b0;
   int         sbase[2] = '{0, 0};

   // monitor logs
   int         rcyc[2] = '{-10, -10};
   logic [7:0] blog[2][NBUF];
   int         bcyc[2][NBUF];
   int         blow[2][NBUF];
   int         nb[2] = '{0, 0};
   int         ndone[2] = '{0, 0};
   int         dcyc[2] = '{0, 0};
   logic       dbusy[2];
   int         lowrun[2] = '{0, 0};

   int         ncmp = 0;
   int         nbad = 0;
   logic [7:0] exp_res[2];
   int         tcyc[7] = '{1, 2, 3, 4, 5, 7, 10};

   function automatic int gapv(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   task automatic check(input string tag, input int got, input int expv);
      ncmp++;
      if (got != expv) begin
         nbad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
      end
   endtask

   // Synchronous source memory and access-controller model: ready 2 cycles after the read command.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         src_data[i] <= mem[src_addr[i]];
         ready[i]    <= (resp_en && (rcyc[i] == cyc - 1)) || stray;
      end
      cyc <= cyc + 1;
   end

   // Byte-stream monitor, sampled on the falling edge
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (valid[i]) begin
            if (nb[i] < NBUF) begin
               blog[i][nb[i]] <= dataw[i];
               bcyc[i][nb[i]] <= cyc;
               blow[i][nb[i]] <= lowrun[i];
            end
            if (nb[i] - sbase[i] == (seq_rdo ? 0 : NW + 1)) rcyc[i] <= cyc;
            nb[i]     <= nb[i] + 1;
            lowrun[i] <= 0;
         end else if (lowrun[i] < 1000) begin
            lowrun[i] <= lowrun[i] + 1;
         end
         if (done[i]) begin
            ndone[i] <= ndone[i] + 1;
            dcyc[i]  <= cyc;
            dbusy[i] <= busy[i];
         end
      end
   end

   task automatic load_mem_random();
      for (int k = 0; k < NW; k++) mem[k] = 8'($urandom);
   endtask

   // One full sequence. mode 1: extra start during the data burst; mode 2: start in the done cycle.
   task automatic run_seq(input bit rdo, input bit resp, input logic [7:0] rdval, input int mode, input bit timed);
      logic [7:0] explist[$];
      int bd[2];
      int t0, w, n, need, rdidx;
      bit fired;
      explist = {};
      if (!rdo) begin
         explist.push_back(8'h80);
         for (int k = 0; k < NW; k++) explist.push_back(mem[k]);
      end
      explist.push_back(8'(RA));
      explist.push_back(8'h00);
      rdidx = rdo ? 0 : NW + 1;

      for (int i = 0; i < 2; i++) begin
         sbase[i] = nb[i];
         bd[i]    = ndone[i];
      end
      seq_rdo = rdo;
      resp_en = resp;
      datar   = rdval;

      start = 1'b1; rd_only = rdo; t0 = cyc;
      @(negedge clk);
      start = 1'b0; rd_only = 1'($urandom);

      if (mode == 1) begin
         w = 0;
         while (nb[0] - sbase[0] < 3 && w < 100) begin @(negedge clk); w++; end
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end

      w = 0; fired = 1'b0;
      while (!(ndone[0] > bd[0] && ndone[1] > bd[1]) && w < 400) begin
         @(negedge clk);
         w++;
         if (mode == 2 && done[0] && !fired) begin
            start = 1'b1; fired = 1'b1;
            @(negedge clk);
            start = 1'b0;
            w++;
         end
      end
      check("seq_completes", int'(w < 400), 1);
      repeat (20) @(negedge clk);

      for (int i = 0; i < 2; i++) begin
         if (resp) exp_res[i] = rdval;
         n = nb[i] - sbase[i];
         check($sformatf("nbytes[%0d]", i), n, explist.size());
         for (int j = 0; j < n && j < explist.size(); j++)
            check($sformatf("byte[%0d][%0d]", i, j), int'(blog[i][sbase[i] + j]), int'(explist[j]));
         for (int j = 1; j < n; j++) begin
            need = gapv(i);
            if (j == rdidx && !rdo && need < 1) need = 1;
            if (need > 0)
               check($sformatf("spacing[%0d][%0d]", i, j), int'(blow[i][sbase[i] + j] >= need), 1);
         end
         check($sformatf("done_count[%0d]", i), ndone[i] - bd[i], 1);
         check($sformatf("busy_at_done[%0d]", i), int'(dbusy[i]), 1);
         check($sformatf("busy_after[%0d]", i), int'(busy[i]), 0);
         check($sformatf("err[%0d]", i), int'(err[i]), int'(!resp));
         check($sformatf("result[%0d]", i), int'(result[i]), int'(exp_res[i]));
      end

      if (timed) begin
         for (int j = 0; j < 7 && j < nb[0] - sbase[0]; j++)
            check($sformatf("byte_cycle[%0d]", j), bcyc[0][sbase[0] + j] - t0, tcyc[j]);
         check("done_cycle", dcyc[0] - t0, 11);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_busy[%0d]", tag, i), int'(busy[i]), 0);
         check($sformatf("%s_valid[%0d]", tag, i), int'(valid[i]), 0);
         check($sformatf("%s_done[%0d]", tag, i), int'(done[i]), 0);
         check($sformatf("%s_err[%0d]", tag, i), int'(err[i]), 0);
         check($sformatf("%s_dataw[%0d]", tag, i), int'(dataw[i]), 0);
         check($sformatf("%s_result[%0d]", tag, i), int'(result[i]), 0);
         check($sformatf("%s_src_addr[%0d]", tag, i), int'(src_addr[i]), 0);
      end
   endtask

   initial begin
      int w, snap;
      logic [7:0] sv;
      rst = 1'b1; start = 1'b0; rd_only = 1'b0; datar = 8'h00;
      exp_res[0] = 8'h00; exp_res[1] = 8'h00;
      for (int k = 0; k < NW; k++) mem[k] = 8'h00;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // directed end-to-end run with exact cycle timing on the GAP=0 instance
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      run_seq(1'b0, 1'b1, 8'h5A, 0, 1'b1);

      // read-only sequence
      load_mem_random();
      run_seq(1'b1, 1'b1, 8'h5A, 0, 1'b0);

      // controller never answers: timeout, result kept, err sticky
      load_mem_random();
      run_seq(1'b0, 1'b0, 8'hE7, 0, 1'b0);

      // next start clears err; extra start during the data burst is ignored
      load_mem_random();
      run_seq(1'b0, 1'b1, 8'($urandom), 1, 1'b0);

      // start in the done cycle is ignored
      load_mem_random();
      run_seq(1'b0, 1'b1, 8'($urandom), 2, 1'b0);

      // stray ready outside a read wait changes nothing
      snap = nb[0];
      sv = ~exp_res[0];
      datar = sv;
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_result0", int'(result[0]), int'(exp_res[0]));
      check("stray_result2", int'(result[1]), int'(exp_res[1]));
      check("stray_nobytes", nb[0] - snap, 0);

      // reset in the middle of the write burst
      load_mem_random();
      sbase[0] = nb[0]; sbase[1] = nb[1];
      seq_rdo = 1'b0; resp_en = 1'b1;
      start = 1'b1; rd_only = 1'b0;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (nb[0] - sbase[0] < 3 && w < 100) begin @(negedge clk); w++; end
      check("reach_wdata", int'(w < 100), 1);
      rst = 1'b1;
      @(negedge clk);
      check_zero_outputs("midrst");
      rst = 1'b0;
      exp_res[0] = 8'h00; exp_res[1] = 8'h00;
      repeat (2) @(negedge clk);
      load_mem_random();
      run_seq(1'b0, 1'b1, 8'($urandom), 0, 1'b0);

      // randomized sequences
      for (int s = 0; s < 8; s++) begin
         load_mem_random();
         run_seq(($urandom % 4) == 0, ($urandom % 4) != 0, 8'($urandom), 0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", ncmp);
      $fatal(1);
   end

endmodule
